// File: rtl/key_conditioner.sv
// Push-button front end: 2-flop synchronizer, polarity normalization, counter-based
// debounce FSM with registered press/release pulses and a one-shot long-press pulse.
module key_conditioner #(
   parameter int unsigned STABLE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES   = 50_000_000,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned CNT_W         = 21,
   parameter int unsigned LCNT_W        = 26
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic KeyRaw,
   output logic KeyLevel,
   output logic Pressed,
   output logic Released,
   output logic LongPress,
   output logic Bouncing
);

   typedef enum logic [1:0] {UP, CHK_DN, DOWN, CHK_UP} state_t;

   localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [LCNT_W-1:0] LONG_LAST   = LCNT_W'(LONG_CYCLES - 1);
   localparam logic [LCNT_W-1:0] LCNT_MAX    = '1;

   logic              sync1, sync2, s;
   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [LCNT_W-1:0] lcnt, lcnt_d;
   logic              level_d, pressed_d, released_d, long_d;

   // Sync flops come out of reset at the idle pin level so reset release never looks like a press.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1 <= ACTIVE_LOW;
         sync2 <= ACTIVE_LOW;
      end else begin
         // NOTE: non-blocking so sync2 takes the old sync1, giving a true two-stage chain.
         sync1 <= KeyRaw;
         sync2 <= sync1;
      end
   end

   assign s = sync2 ^ ACTIVE_LOW;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state;
      cnt_d      = cnt;
      lcnt_d     = lcnt;
      level_d    = KeyLevel;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      long_d     = 1'b0;

      // Saturating hold timer; it passes LONG_LAST exactly once per hold, so no fired flag is needed.
      if (KeyLevel && (lcnt != LCNT_MAX)) lcnt_d = lcnt + 1'b1;
      if (KeyLevel && (lcnt == LONG_LAST)) long_d = 1'b1;

      unique case (state)
         UP: begin
            if (s) begin
               state_d = CHK_DN;
               cnt_d   = CNT_W'(1);
            end
         end
         CHK_DN: begin
            if (!s) begin
               state_d = UP;
               cnt_d   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_d   = DOWN;
               level_d   = 1'b1;
               pressed_d = 1'b1;
               cnt_d     = '0;
               lcnt_d    = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DOWN: begin
            if (!s) begin
               state_d = CHK_UP;
               cnt_d   = CNT_W'(1);
            end
         end
         CHK_UP: begin
            if (s) begin
               state_d = DOWN;
               cnt_d   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_d    = UP;
               level_d    = 1'b0;
               released_d = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            state_d = UP;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= UP;
         cnt       <= '0;
         lcnt      <= '0;
         KeyLevel  <= 1'b0;
         Pressed   <= 1'b0;
         Released  <= 1'b0;
         LongPress <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         lcnt      <= lcnt_d;
         KeyLevel  <= level_d;
         Pressed   <= pressed_d;
         Released  <= released_d;
         LongPress <= long_d;
      end
   end

   assign Bouncing = (state == CHK_DN) || (state == CHK_UP);

endmodule
